// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: signal bundle for the programmable serial-pattern detector.
//   master : stream/config source (drives cfg_load, pattern, pat_len, overlap,
//            in_valid, in; observes out, match_count, count_sat)
//   slave  : the detector itself (the opposite directions)
interface seq_detect_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               in_valid;
  logic               in;
  logic               out;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;

  modport master (
    output cfg_load, pattern, pat_len, overlap, in_valid, in,
    input  out, match_count, count_sat
  );

  modport slave (
    input  cfg_load, pattern, pat_len, overlap, in_valid, in,
    output out, match_count, count_sat
  );
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param: Mealy serial-pattern detector with a run-time programmable
// pattern of 1..MAX_LEN bits, overlapping / non-overlapping matching and a
// saturating match counter.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low; returns the block to disabled
//   bus    - seq_detect_param_if.slave: config (cfg_load, pattern, pat_len,
//            overlap), stream (in_valid, in) and results (out, match_count,
//            count_sat)
// pattern[L-1] is the first bit of the sequence, pattern[0] the last.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  seq_detect_param_if.slave   bus
);

  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_ovl;
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fcnt;
  logic [CNT_W-1:0]   cnt;
  logic               sat;

  logic               enabled;
  logic [LEN_W-1:0]   len_m1;
  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic               match;

  // Lengths of 0 or above MAX_LEN park the block (also the reset state).
  assign enabled = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
  assign len_m1  = cfg_len - LEN_W'(1);

  // Full-width window, newest bit at [0]; only the low cfg_len bits take part
  // in the compare, which gives w = {hist[L-2:0], in} for every L.
  assign win = {hist, bus.in};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (i < int'(cfg_len));
  end

  // cfg_load has priority: a bit arriving with it is discarded, so no strobe.
  assign match = bus.in_valid && !bus.cfg_load && enabled &&
                 (fcnt >= len_m1) && (((win ^ cfg_pat) & mask) == '0);

  assign bus.out         = match;
  assign bus.match_count = cnt;
  assign bus.count_sat   = sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_pat <= '0;
      cfg_len <= '0;
      cfg_ovl <= 1'b1;
      hist    <= '0;
      fcnt    <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
    end else if (bus.cfg_load) begin
      cfg_pat <= bus.pattern;
      cfg_len <= bus.pat_len;
      cfg_ovl <= bus.overlap;
      hist    <= '0;
      fcnt    <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
    end else if (bus.in_valid && enabled) begin
      hist <= win[MAX_LEN-2:0];
      // Non-overlapping restarts the fill so matched bits are not reused.
      if (match && !cfg_ovl)
        fcnt <= '0;
      else if (fcnt < len_m1)
        fcnt <= fcnt + LEN_W'(1);
      if (match) begin
        if (cnt != '1)
          cnt <= cnt + CNT_W'(1);
        else
          sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_detect_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) bus ();
  seq_detect_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) sbus ();

  seq_detect_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .bus(bus));
  seq_detect_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .bus(sbus));

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ld, input bit v, input bit b);
    bus.cfg_load = ld;  sbus.cfg_load = ld;
    bus.in_valid = v;   sbus.in_valid = v;
    bus.in       = b;   sbus.in       = b;
  endtask

  task automatic set_cfg(input logic [7:0] p, input logic [3:0] l, input bit o);
    bus.pattern = p;  sbus.pattern = p;
    bus.pat_len = l;  sbus.pat_len = l;
    bus.overlap = o;  sbus.overlap = o;
  endtask

  // One cycle: expected strobe queued at drive time, compared mid-cycle.
  task automatic step(input string tag, input bit ld, input bit v, input bit b, input bit e);
    bit x;
    drive(ld, v, b);
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    chk(tag, bus.out, x);
    chk({tag, "_s"}, sbus.out, x);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // Load, then scramble the config inputs to show they are only captured on cfg_load.
  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
    set_cfg(p, l, o);
    step("load_out", 1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(~p, 4'd0, ~o);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    set_cfg(8'h00, 4'd0, 1'b1);
    #12;
    chk("rst_out", bus.out, 0);
    chk("rst_cnt", bus.match_count, 0);
    chk("rst_sat", bus.count_sat, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    // Disabled after reset: no detection without cfg_load.
    step("dis_out", 1'b0, 1'b1, 1'b1, 1'b0);

    // Overlapping 1101
    load(8'b00001101, 4'd4, 1'b1);
    step("ov1", 0, 1, 1, 0); step("ov2", 0, 1, 1, 0); step("ov3", 0, 1, 0, 0);
    step("ov4", 0, 1, 1, 1); step("ov5", 0, 1, 1, 0); step("ov6", 0, 1, 0, 0);
    step("ov7", 0, 1, 1, 1);
    chk("ov_cnt", bus.match_count, 2);

    // Non-overlapping 1101
    load(8'b00001101, 4'd4, 1'b0);
    step("no1", 0, 1, 1, 0); step("no2", 0, 1, 1, 0); step("no3", 0, 1, 0, 0);
    step("no4", 0, 1, 1, 1); step("no5", 0, 1, 1, 0); step("no6", 0, 1, 0, 0);
    step("no7", 0, 1, 1, 0);
    chk("no_cnt", bus.match_count, 1);

    // Gap in the stream, then L=1
    load(8'b00001101, 4'd4, 1'b1);
    step("gp1", 0, 1, 1, 0); step("gp2", 0, 1, 1, 0); step("gp_inv", 0, 0, 1, 0);
    step("gp3", 0, 1, 0, 0); step("gp4", 0, 1, 1, 1);
    chk("gp_cnt", bus.match_count, 1);
    load(8'b00000001, 4'd1, 1'b1);
    step("l1_1", 0, 1, 1, 1); step("l1_2", 0, 1, 0, 0); step("l1_3", 0, 1, 1, 1);
    chk("l1_cnt", bus.match_count, 2);

    // Saturation on the CNT_W=2 instance
    load(8'b00000001, 4'd1, 1'b1);
    for (int i = 0; i < 3; i++) step("sat_a", 0, 1, 1, 1);
    chk("sat_cnt3", sbus.match_count, 3);
    chk("sat_flag0", sbus.count_sat, 0);
    for (int i = 0; i < 2; i++) step("sat_b", 0, 1, 1, 1);
    chk("sat_cnt", sbus.match_count, 3);
    chk("sat_flag", sbus.count_sat, 1);
    chk("wide_cnt", bus.match_count, 5);
    chk("wide_flag", bus.count_sat, 0);
    load(8'b00000001, 4'd1, 1'b1);
    chk("sat_clr_cnt", sbus.match_count, 0);
    chk("sat_clr_flag", sbus.count_sat, 0);

    // Asynchronous reset mid-stream
    load(8'b00001101, 4'd4, 1'b1);
    step("rs1", 0, 1, 1, 0); step("rs2", 0, 1, 1, 0); step("rs3", 0, 1, 0, 0);
    step("rs4", 0, 1, 1, 1);
    step("rs5", 0, 1, 1, 0); step("rs6", 0, 1, 0, 0);
    drive(1'b0, 1'b1, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rs_cnt", bus.match_count, 0);
    chk("rs_out", bus.out, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step("rs_dis", 0, 1, 1, 0);
    load(8'b00001101, 4'd4, 1'b1);
    step("rs_after", 0, 1, 1, 0);
    chk("rs_cnt2", bus.match_count, 0);

    // cfg_load coincident with a would-be matching bit
    load(8'b00001101, 4'd4, 1'b1);
    step("cl1", 0, 1, 1, 0); step("cl2", 0, 1, 1, 0); step("cl3", 0, 1, 0, 0);
    set_cfg(8'b00001101, 4'd4, 1'b1);
    step("cl_coinc", 1, 1, 1, 0);
    chk("cl_cnt", bus.match_count, 0);
    step("cl_after", 0, 1, 1, 0);

    // Illegal lengths keep the block disabled
    load(8'hFF, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) step("len0", 0, 1, 1, 0);
    chk("len0_cnt", bus.match_count, 0);
    load(8'hFF, 4'd9, 1'b1);
    for (int i = 0; i < 10; i++) step("len9", 0, 1, 1, 0);
    chk("len9_cnt", bus.match_count, 0);

    // L=MAX_LEN, all ones
    load(8'hFF, 4'd8, 1'b1);
    for (int i = 1; i <= 10; i++) step("lmax", 0, 1, 1, (i >= 8));
    chk("lmax_cnt", bus.match_count, 3);
    chk("lmax_scnt", sbus.match_count, 3);
    chk("lmax_sflag", sbus.count_sat, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
